// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/bubble sequencer.
// Holds the memory-wait FSM encodings, control-level constants and the bundled control word.
package pipe_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        PC_ST_IDLE = 2'd0,
        PC_ST_WAIT = 2'd1,
        PC_ST_ERR  = 2'd2
    } pc_state_e;

    localparam logic STALL_YES  = 1'b1;
    localparam logic STALL_NO   = 1'b0;
    localparam logic BUBBLE_YES = 1'b1;
    localparam logic BUBBLE_NO  = 1'b0;

    // Every per-register control emitted in one cycle, plus the dmem request strobe.
    typedef struct packed {
        logic f_stall;
        logic d_stall;
        logic d_bubble;
        logic e_stall;
        logic e_bubble;
        logic m_stall;
        logic w_bubble;
        logic req;
    } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// Load-use hazard detector: the instruction in D reads the destination of a load sitting in E.
// Purely combinational so the forwarding unit can reuse it.
module pipe_ctrl_hazard
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic             rs1_ren,
    input  logic             rs2_ren,
    input  logic [REG_W-1:0] e_rd,
    input  logic             e_is_load,
    output logic             luse
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = rs1_ren && (rs1 == e_rd);
    assign rs2_hit = rs2_ren && (rs2 == e_rd);

    // x0 is never really written, so a load targeting it cannot create a dependency.
    assign luse = e_is_load && (e_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/bubble sequencer for regF..regW: load-use, E-stage redirect and dmem waits,
// with a memory-wait timeout FSM and a saturating count of fetch-stall cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  decode_i_rs1,
    input  logic [4:0]  decode_i_rs2,
    input  logic        decode_i_rs1_ren,
    input  logic        decode_i_rs2_ren,
    input  logic [4:0]  regE_i_wb_rd,
    input  logic        regE_i_is_load,
    input  logic        execute_i_redirect,
    input  logic        regM_i_mem_en,
    input  logic        dmem_i_ready,
    output logic        dmem_o_req,
    output logic        regF_o_stall,
    output logic        regD_o_stall,
    output logic        regD_o_bubble,
    output logic        regE_o_stall,
    output logic        regE_o_bubble,
    output logic        regM_o_stall,
    output logic        regW_o_bubble,
    output logic        ctrl_o_timeout,
    output logic [31:0] ctrl_o_stall_cnt
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    pc_state_e        state;
    pc_state_e        state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;
    logic [31:0]      stall_cnt;
    logic             luse;
    logic             flow;
    ctrl_t            ctrl;
    ctrl_t            ctrl_out;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    pipe_ctrl_hazard u_hazard (
        .rs1       (decode_i_rs1),
        .rs2       (decode_i_rs2),
        .rs1_ren   (decode_i_rs1_ren),
        .rs2_ren   (decode_i_rs2_ren),
        .e_rd      (regE_i_wb_rd),
        .e_is_load (regE_i_is_load),
        .luse      (luse)
    );

    // The pipeline flows normally in IDLE and in the wait cycle where dmem finally answers.
    assign flow = (state == PC_ST_IDLE) || ((state == PC_ST_WAIT) && dmem_i_ready);

    always_comb begin
        state_next = state;
        ctrl       = '0;
        case (state)
            PC_ST_IDLE: begin
                ctrl.req = regM_i_mem_en;
                if (regM_i_mem_en && !dmem_i_ready) begin
                    state_next = PC_ST_WAIT;
                end
            end
            PC_ST_WAIT: begin
                ctrl.req = 1'b1;
                if (dmem_i_ready) begin
                    state_next = PC_ST_IDLE;
                end else begin
                    ctrl.f_stall  = STALL_YES;
                    ctrl.d_stall  = STALL_YES;
                    ctrl.e_stall  = STALL_YES;
                    ctrl.m_stall  = STALL_YES;
                    ctrl.w_bubble = BUBBLE_YES;
                    if (wait_cnt == TIMEOUT_C) begin
                        state_next = PC_ST_ERR;
                    end
                end
            end
            PC_ST_ERR: begin
                ctrl.f_stall  = STALL_YES;
                ctrl.d_stall  = STALL_YES;
                ctrl.e_stall  = STALL_YES;
                ctrl.m_stall  = STALL_YES;
                ctrl.w_bubble = BUBBLE_YES;
            end
            default: begin
                state_next = PC_ST_IDLE;
            end
        endcase

        // Redirect squashes the wrong-path instructions in D and E; it outranks load-use.
        if (flow) begin
            if (execute_i_redirect) begin
                ctrl.d_bubble = BUBBLE_YES;
                ctrl.e_bubble = BUBBLE_YES;
            end else if (luse) begin
                ctrl.f_stall  = STALL_YES;
                ctrl.d_stall  = STALL_YES;
                ctrl.e_bubble = BUBBLE_YES;
            end
        end
    end

    assign ctrl_out = rst ? ctrl : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= PC_ST_IDLE;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == PC_ST_IDLE) begin
                wait_cnt <= CNT_W'(1);
            end else if ((state == PC_ST_WAIT) && !dmem_i_ready && (wait_cnt != TIMEOUT_C)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state_next == PC_ST_ERR) begin
                timeout_q <= 1'b1;
            end
            if (ctrl_out.f_stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

    assign dmem_o_req       = ctrl_out.req;
    assign regF_o_stall     = ctrl_out.f_stall;
    assign regD_o_stall     = ctrl_out.d_stall;
    assign regD_o_bubble    = ctrl_out.d_bubble;
    assign regE_o_stall     = ctrl_out.e_stall;
    assign regE_o_bubble    = ctrl_out.e_bubble;
    assign regM_o_stall     = ctrl_out.m_stall;
    assign regW_o_bubble    = ctrl_out.w_bubble;
    assign ctrl_o_timeout   = timeout_q;
    assign ctrl_o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard/wait/timeout scenarios plus random traffic,
// all checked against a cycle-level behavioural model of the sequencing rules.
module tb_pipe_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1, rs2, e_rd;
    logic        rs1_ren, rs2_ren, e_is_load, redirect, mem_en, ready;
    logic        req, f_stall, d_stall, d_bubble, e_stall, e_bubble, m_stall, w_bubble;
    logic        timeout;
    logic [31:0] stall_cnt;
    logic [7:0]  dut_vec;
    logic [7:0]  last_vec;

    int total = 0;
    int bad   = 0;

    // Model: outstanding-access age (0 = none), dead after timeout, fetch-stall tally.
    int          m_age;
    bit          m_err;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .decode_i_rs1       (rs1),
        .decode_i_rs2       (rs2),
        .decode_i_rs1_ren   (rs1_ren),
        .decode_i_rs2_ren   (rs2_ren),
        .regE_i_wb_rd       (e_rd),
        .regE_i_is_load     (e_is_load),
        .execute_i_redirect (redirect),
        .regM_i_mem_en      (mem_en),
        .dmem_i_ready       (ready),
        .dmem_o_req         (req),
        .regF_o_stall       (f_stall),
        .regD_o_stall       (d_stall),
        .regD_o_bubble      (d_bubble),
        .regE_o_stall       (e_stall),
        .regE_o_bubble      (e_bubble),
        .regM_o_stall       (m_stall),
        .regW_o_bubble      (w_bubble),
        .ctrl_o_timeout     (timeout),
        .ctrl_o_stall_cnt   (stall_cnt)
    );

    assign dut_vec = {f_stall, d_stall, d_bubble, e_stall, e_bubble, m_stall, w_bubble, req};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected {F stall, D stall, D bubble, E stall, E bubble, M stall, W bubble, req}.
    function automatic logic [7:0] model_vec();
        logic [7:0] v;
        bit luse;
        v = 8'h00;
        luse = e_is_load && (e_rd != 5'd0) &&
               ((rs1_ren && rs1 == e_rd) || (rs2_ren && rs2 == e_rd));
        if (m_err) begin
            v = 8'b1101_0110;
        end else if (m_age > 0 && !ready) begin
            v = 8'b1101_0111;
        end else begin
            v[0] = (m_age > 0) ? 1'b1 : mem_en;
            if (redirect) begin
                v[5] = 1'b1;
                v[3] = 1'b1;
            end else if (luse) begin
                v[7] = 1'b1;
                v[6] = 1'b1;
                v[3] = 1'b1;
            end
        end
        return v;
    endfunction

    task automatic model_advance(input bit f_st);
        if (f_st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (!m_err) begin
            if (m_age > 0) begin
                if (ready) m_age = 0;
                else if (m_age == TIMEOUT) begin
                    m_err = 1'b1;
                    m_age = 0;
                end else m_age++;
            end else if (mem_en && !ready) begin
                m_age = 1;
            end
        end
    endtask

    task automatic step(input logic [4:0] a1, input logic [4:0] a2, input logic en1, input logic en2,
                        input logic [4:0] rd, input logic ld, input logic rdr, input logic men,
                        input logic rdy, input string tag);
        logic [7:0] exp;
        @(posedge clk);
        #1;
        rs1 = a1; rs2 = a2; rs1_ren = en1; rs2_ren = en2;
        e_rd = rd; e_is_load = ld; redirect = rdr; mem_en = men; ready = rdy;
        exp = model_vec();
        @(negedge clk);
        check_val({tag, "_ctl"}, 32'(dut_vec), 32'(exp));
        check_val({tag, "_cnt"}, stall_cnt, m_cnt);
        check_val({tag, "_to"}, 32'(timeout), 32'(m_err));
        last_vec = dut_vec;
        model_advance(exp[7]);
    endtask

    task automatic idle_step(input string tag);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    // Asserts reset between edges with whatever inputs are live and checks the outputs die at once.
    task automatic apply_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_val({tag, "_out"}, 32'(dut_vec), 32'd0);
        check_val({tag, "_to"}, 32'(timeout), 32'd0);
        check_val({tag, "_cnt"}, stall_cnt, 32'd0);
        rs1 = '0; rs2 = '0; rs1_ren = 0; rs2_ren = 0; e_rd = '0;
        e_is_load = 0; redirect = 0; mem_en = 0; ready = 0;
        m_age = 0; m_err = 0; m_cnt = 32'd0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        rs1 = '0; rs2 = '0; rs1_ren = 0; rs2_ren = 0; e_rd = '0;
        e_is_load = 0; redirect = 0; mem_en = 0; ready = 0;
        m_age = 0; m_err = 0; m_cnt = 32'd0; last_vec = '0;
        #12;
        check_val("init_out", 32'(dut_vec), 32'd0);
        check_val("init_cnt", stall_cnt, 32'd0);
        check_val("init_to", 32'(timeout), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Load-use on rs1: one stall cycle, then free flow.
        step(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, "luse_c0");
        check_val("luse_c0_vec", 32'(last_vec), 32'h0000_00C8);
        step(5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, "luse_c1");
        check_val("luse_c1_vec", 32'(last_vec), 32'd0);
        check_val("luse_cnt", stall_cnt, 32'd1);

        // Load to x0 never stalls.
        step(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, "ldx0");
        check_val("ldx0_vec", 32'(last_vec), 32'd0);

        // Three stalled wait cycles, then ready releases the pipe in the same cycle.
        apply_reset("rst_a");
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, "mw_req");
        check_val("mw_req_vec", 32'(last_vec), 32'h0000_0001);
        for (int i = 0; i < 3; i++) begin
            step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, "mw_wait");
            check_val("mw_wait_vec", 32'(last_vec), 32'h0000_00D7);
        end
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, "mw_done");
        check_val("mw_done_vec", 32'(last_vec), 32'h0000_0001);
        idle_step("mw_idle");
        check_val("mw_cnt", stall_cnt, 32'd3);

        // Redirect beats load-use.
        step(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, "rdr_luse");
        check_val("rdr_luse_vec", 32'(last_vec), 32'h0000_0028);

        // Redirect raised during a wait takes effect in the cycle dmem answers.
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, "wr_req");
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, "wr_w1");
        check_val("wr_w1_vec", 32'(last_vec), 32'h0000_00D7);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, "wr_w2");
        check_val("wr_w2_vec", 32'(last_vec), 32'h0000_0029);
        idle_step("wr_idle");

        // Timeout: four unanswered wait cycles, then a sticky error.
        apply_reset("rst_b");
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, "to_req");
        for (int i = 0; i < TIMEOUT; i++)
            step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, "to_wait");
        check_val("to_pre", 32'(timeout), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, "to_err");
            check_val("to_err_vec", 32'(last_vec), 32'h0000_00D6);
            check_val("to_err_flag", 32'(timeout), 32'd1);
        end
        mem_en = 1'b1; rs1 = 5'd3; rs1_ren = 1'b1; e_rd = 5'd3; e_is_load = 1'b1;
        apply_reset("rst_err");

        // Random traffic; reset on error or occasionally mid-flight.
        for (int n = 0; n < 600; n++) begin
            logic men;
            men = (m_age > 0) ? 1'b1 : ($urandom_range(2, 0) == 0);
            step(5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
                 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                 5'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                 ($urandom_range(3, 0) == 0), men, ($urandom_range(2, 0) != 0), "rnd");
            if ((m_err && $urandom_range(3, 0) == 0) || $urandom_range(99, 0) == 0)
                apply_reset("rnd_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
